// File: rtl/keypad_emulator.sv
// Responder side of a 4x3 matrix-keypad scan: queues key codes, then answers the
// row scan on the column lines. Optional contact bounce: KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator #(
   parameter int FIFO_DEPTH    = 4,
   parameter int PRESS_CYCLES  = 20000,
   parameter int GAP_CYCLES    = 20000,
   parameter int BOUNCE_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    keyboard_rows,
   input  logic                          key_valid,
   input  logic [3:0]                    key_code,
   output logic                          key_ready,
   output logic [2:0]                    keyboard_cols,
   output logic                          busy,
   output logic                          key_active,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_invalid
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int MAXC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [AW:0]   DEPTH_C    = AW'(0) + (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0))
      $error("FIFO_DEPTH must be a power of 2 and >= 2");
   if ((PRESS_CYCLES < 1) || (GAP_CYCLES < 1) || (BOUNCE_CYCLES >= PRESS_CYCLES))
      $error("bad PRESS/GAP/BOUNCE cycle parameters");

   typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      held_q, held_d;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q, count_d;
   logic            err_q;
   logic [3:0]      mem_q [FIFO_DEPTH];

   logic            full, empty, accept, push, pop, closed;
   logic [1:0]      row_idx;
   logic [2:0]      col_mask;

   assign full   = (count_q == DEPTH_C);
   assign empty  = (count_q == '0);
   assign accept = key_valid & ~full;
   // Out-of-range codes are swallowed at the port and never reach the queue.
   assign push   = accept & (key_code < 4'd12);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= key_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         held_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         held_q   <= held_d;
         count_q  <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (accept && key_code >= 4'd12) err_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      held_d  = held_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               held_d  = mem_q[rd_ptr_q];
               cnt_d   = '0;
               state_d = S_PRESS;
            end
         end
         S_PRESS: begin
            if (cnt_q == PRESS_LAST) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  held_d  = mem_q[rd_ptr_q];
                  state_d = S_PRESS;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Keypad layout: row = code/3, column = code%3.
   always_comb begin
      row_idx  = 2'd0;
      col_mask = 3'b000;
      case (held_q)
         4'd0:  begin row_idx = 2'd0; col_mask = 3'b001; end
         4'd1:  begin row_idx = 2'd0; col_mask = 3'b010; end
         4'd2:  begin row_idx = 2'd0; col_mask = 3'b100; end
         4'd3:  begin row_idx = 2'd1; col_mask = 3'b001; end
         4'd4:  begin row_idx = 2'd1; col_mask = 3'b010; end
         4'd5:  begin row_idx = 2'd1; col_mask = 3'b100; end
         4'd6:  begin row_idx = 2'd2; col_mask = 3'b001; end
         4'd7:  begin row_idx = 2'd2; col_mask = 3'b010; end
         4'd8:  begin row_idx = 2'd2; col_mask = 3'b100; end
         4'd9:  begin row_idx = 2'd3; col_mask = 3'b001; end
         4'd10: begin row_idx = 2'd3; col_mask = 3'b010; end
         4'd11: begin row_idx = 2'd3; col_mask = 3'b100; end
         default: begin row_idx = 2'd0; col_mask = 3'b000; end
      endcase
   end

`ifdef KEYPAD_EMU_BOUNCE_EN
   logic [31:0] cnt_ext;
   assign cnt_ext = 32'(cnt_q);
   // Contact chatters in 4-clock phases, closed first, then settles closed.
   assign closed  = (cnt_ext >= 32'(BOUNCE_CYCLES)) || !cnt_ext[2];
`else
   assign closed  = 1'b1;
`endif

   always_comb begin
      keyboard_cols = 3'b111;
      if (state_q == S_PRESS && closed && !keyboard_rows[row_idx])
         keyboard_cols = ~col_mask;
   end

   assign key_ready   = ~full;
   assign busy        = (state_q != S_IDLE) | ~empty;
   assign key_active  = (state_q == S_PRESS);
   assign fifo_count  = count_q;
   assign err_invalid = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with short press/gap timing.
module tb_keypad_emulator;
   localparam int DEPTH = 4;
   localparam int PRESS = 8;
   localparam int GAP   = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] keyboard_rows = 4'b1111;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       key_ready, busy, key_active, err_invalid;
   logic [2:0] keyboard_cols;
   logic [2:0] fifo_count;

   int total = 0;
   int bad   = 0;

   keypad_emulator #(.FIFO_DEPTH(DEPTH), .PRESS_CYCLES(PRESS), .GAP_CYCLES(GAP),
                     .BOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .keyboard_rows(keyboard_rows), .key_valid(key_valid),
      .key_code(key_code), .key_ready(key_ready), .keyboard_cols(keyboard_cols),
      .busy(busy), .key_active(key_active), .fifo_count(fifo_count),
      .err_invalid(err_invalid));

   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 200) begin tick(); n++; end
      check(tag, 32'(busy), 32'd0);
   endtask

   function automatic logic [3:0] row_pat(input logic [3:0] code);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << (code / 3));
   endfunction

   function automatic logic [2:0] col_pat(input logic [3:0] code);
      logic [2:0] one;
      one = 3'b001;
      return ~(one << (code % 3));
   endfunction

   logic [3:0] seq [6];
   logic [2:0] seq_cnt [6];

   initial begin
      int g, p;
      logic ok;
      seq     = '{4'd0, 4'd5, 4'd9, 4'd11, 4'd3, 4'd7};
      seq_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

      // reset state
      tick(); tick();
      check("rst_cols",  32'(keyboard_cols), 32'h7);
      check("rst_ready", 32'(key_ready),     32'd1);
      check("rst_busy",  32'(busy),          32'd0);
      check("rst_act",   32'(key_active),    32'd0);
      check("rst_cnt",   32'(fifo_count),    32'd0);
      check("rst_err",   32'(err_invalid),   32'd0);
      rst = 1'b0;
      tick();

      // key '5' on its own row: held for PRESS cycles, then a clean gap
      keyboard_rows = 4'b1101; key_valid = 1'b1; key_code = 4'd4;
      tick();
      key_valid = 1'b0;
      check("t1_cnt1", 32'(fifo_count),    32'd1);
      check("t1_busy", 32'(busy),          32'd1);
      check("t1_pre",  32'(keyboard_cols), 32'h7);
      tick();
      check("t1_act",  32'(key_active),    32'd1);
      check("t1_cols", 32'(keyboard_cols), 32'b101);
      check("t1_cnt0", 32'(fifo_count),    32'd0);
      for (int i = 1; i < PRESS; i++) begin
         tick();
         check("t1_hold", 32'(keyboard_cols), 32'b101);
      end
      tick();
      check("t1_rel",   32'(keyboard_cols), 32'h7);
      check("t1_gap",   32'(key_active),    32'd0);
      check("t1_gbusy", 32'(busy),          32'd1);
      repeat (GAP - 1) tick();
      check("t1_gend", 32'(busy), 32'd1);
      tick();
      check("t1_idle", 32'(busy), 32'd0);

      // wrong row, multi-row, no row
      keyboard_rows = 4'b1011; key_valid = 1'b1; key_code = 4'd4;
      tick();
      key_valid = 1'b0;
      tick();
      check("t2_act",   32'(key_active),    32'd1);
      check("t2_wrong", 32'(keyboard_cols), 32'h7);
      keyboard_rows = 4'b1001; #1;
      check("t2_multi", 32'(keyboard_cols), 32'b101);
      keyboard_rows = 4'b1111; #1;
      check("t2_none",  32'(keyboard_cols), 32'h7);
      wait_idle("t2_idle");

      // overfill: first press pops one entry, so six pushes fill it and drop the last
      keyboard_rows = row_pat(seq[0]);
      for (int i = 0; i < 6; i++) begin
         key_valid = 1'b1; key_code = seq[i];
         tick();
         check("t3_fill", 32'(fifo_count), 32'(seq_cnt[i]));
      end
      key_valid = 1'b0;
      check("t3_full", 32'(key_ready), 32'd0);
      for (int k = 0; k < 5; k++) begin
         keyboard_rows = row_pat(seq[k]); #1;
         g = 0; ok = 1'b1;
         while (!key_active && g < 50) begin
            if (keyboard_cols !== 3'b111) ok = 1'b0;
            tick(); g++;
         end
         if (k > 0) check("t3_gaplen", 32'(g), 32'(GAP));
         check("t3_gapcols", 32'(ok), 32'd1);
         p = 0; ok = 1'b1;
         while (key_active && p < 50) begin
            if (keyboard_cols !== col_pat(seq[k])) ok = 1'b0;
            tick(); p++;
         end
         if (k > 0) check("t3_presslen", 32'(p), 32'(PRESS));
         check("t3_keycols", 32'(ok), 32'd1);
      end
      wait_idle("t3_idle");
      check("t3_empty", 32'(fifo_count), 32'd0);

      // invalid code
      key_valid = 1'b1; key_code = 4'd13;
      tick();
      key_valid = 1'b0;
      check("t4_err",  32'(err_invalid), 32'd1);
      check("t4_cnt",  32'(fifo_count),  32'd0);
      check("t4_busy", 32'(busy),        32'd0);
      tick();
      check("t4_busy2", 32'(busy), 32'd0);

      // reset mid-press with one entry still queued
      key_valid = 1'b1; key_code = 4'd2;
      tick();
      key_code = 4'd6;
      tick();
      key_valid = 1'b0; keyboard_rows = 4'b1110; #1;
      check("t5_act",    32'(key_active),    32'd1);
      check("t5_cols",   32'(keyboard_cols), 32'b011);
      check("t5_cnt",    32'(fifo_count),    32'd1);
      check("t5_sticky", 32'(err_invalid),   32'd1);
      rst = 1'b1; #1;
      check("t5_rcols", 32'(keyboard_cols), 32'h7);
      check("t5_rcnt",  32'(fifo_count),    32'd0);
      check("t5_rerr",  32'(err_invalid),   32'd0);
      check("t5_ract",  32'(key_active),    32'd0);
      check("t5_rrdy",  32'(key_ready),     32'd1);
      tick();
      rst = 1'b0;
      tick();
      check("t5_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
